// File: rtl/jtopll_pkg.sv
// Shared definitions for the OPLL host write queue: bus-sequencer state encoding
// and the chip's default write-recovery waits (in cen ticks).
package jtopll_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        AWAIT = 3'd2,
        DATA  = 3'd3,
        DWAIT = 3'd4
    } wrq_state_t;

    localparam int OPLL_ADDR_WAIT = 12;
    localparam int OPLL_DATA_WAIT = 84;

endpackage

// File: rtl/jtopll_fifo.sv
// Generic synchronous FIFO with registered occupancy. Push and pop in the same
// cycle leave the level unchanged; pointers wrap modulo DEPTH.
module jtopll_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push && (level != FULL);
    assign do_pop  = pop && (level != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/jtopll_wrq.sv
// Host register-write queue for the OPLL core: buffers (reg, value) pairs and
// replays each as an address strobe then a data strobe, with cen-paced recovery waits.
module jtopll_wrq
    import jtopll_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int CW        = 8,
    parameter int ADDR_WAIT = OPLL_ADDR_WAIT,
    parameter int DATA_WAIT = OPLL_DATA_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [7:0]  req_reg,
    input  logic [7:0]  req_data,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [AW:0] level,
    output logic        busy,
    output logic [7:0]  dout,
    output logic        addr,
    output logic        cs_n,
    output logic        wr_n
);

    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] ADDR_LOAD = CW'(ADDR_WAIT - 1);
    localparam logic [CW-1:0] DATA_LOAD = CW'(DATA_WAIT - 1);

    wrq_state_t    state;
    wrq_state_t    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          cs_n_n;
    logic          wr_n_n;
    logic          addr_n;
    logic [7:0]    dout_n;
    logic [7:0]    cmd_data;
    logic [15:0]   head;
    logic          push;
    logic          pop;

    assign req_ready = !rst && (level != FULL);
    assign push      = req_valid && req_ready;
    assign busy      = (state != IDLE) || (level != '0);

    jtopll_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({req_reg, req_data}),
        .pop   (pop),
        .rdata (head),
        .level (level)
    );

    // Bus outputs are computed one tick ahead so the registered strobe lines up
    // with the state that owns it; with cen low everything holds.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cs_n_n  = cs_n;
        wr_n_n  = wr_n;
        addr_n  = addr;
        dout_n  = dout;
        pop     = 1'b0;
        if (cen) begin
            cs_n_n = 1'b1;
            wr_n_n = 1'b1;
            case (state)
                IDLE: begin
                    if (level != '0) begin
                        pop     = 1'b1;
                        state_n = ADDR;
                        cs_n_n  = 1'b0;
                        wr_n_n  = 1'b0;
                        addr_n  = 1'b0;
                        dout_n  = head[15:8];
                    end
                end
                ADDR: begin
                    state_n = AWAIT;
                    cnt_n   = ADDR_LOAD;
                end
                AWAIT: begin
                    if (cnt == '0) begin
                        state_n = DATA;
                        cs_n_n  = 1'b0;
                        wr_n_n  = 1'b0;
                        addr_n  = 1'b1;
                        dout_n  = cmd_data;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                DATA: begin
                    state_n = DWAIT;
                    cnt_n   = DATA_LOAD;
                end
                DWAIT: begin
                    if (cnt == '0) begin
                        // Chain straight into the next entry without an IDLE tick.
                        if (level != '0) begin
                            pop     = 1'b1;
                            state_n = ADDR;
                            cs_n_n  = 1'b0;
                            wr_n_n  = 1'b0;
                            addr_n  = 1'b0;
                            dout_n  = head[15:8];
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
            addr  <= 1'b0;
            dout  <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cs_n  <= cs_n_n;
            wr_n  <= wr_n_n;
            addr  <= addr_n;
            dout  <= dout_n;
        end
    end

    // Register value is parked here while the address phase and its wait run.
    always_ff @(posedge clk) begin
        if (pop) cmd_data <= head[7:0];
    end

endmodule

// File: tb/tb_jtopll_wrq.sv
// Self-checking bench for jtopll_wrq: a queue-based model predicts strobe order,
// tick spacing, level, busy and ready; directed tables and sequences cover corners.
module tb_jtopll_wrq;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AWT   = 12;
    localparam int DWT   = 84;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cen = 1'b0;
    logic [7:0]  req_reg = 8'h00;
    logic [7:0]  req_data = 8'h00;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [AW:0] level;
    logic        busy;
    logic [7:0]  dout;
    logic        addr;
    logic        cs_n;
    logic        wr_n;

    jtopll_wrq #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .CW        (8),
        .ADDR_WAIT (AWT),
        .DATA_WAIT (DWT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .level     (level),
        .busy      (busy),
        .dout      (dout),
        .addr      (addr),
        .cs_n      (cs_n),
        .wr_n      (wr_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // cen pacing: 0 = stuck low, N = every Nth clock, 255 = random
    int cen_mode = 1;
    int cen_ph = 0;
    initial forever begin
        @(posedge clk);
        #2;
        if (cen_mode == 0) cen = 1'b0;
        else if (cen_mode == 255) cen = ($urandom_range(0, 2) == 0);
        else begin
            cen = (cen_ph == 0);
            cen_ph = (cen_ph + 1) % cen_mode;
        end
    end

    int tick = 0;
    initial forever begin
        @(posedge clk);
        if (cen) tick = tick + 1;
    end

    // Reference model: pushed entries in order plus their push tick.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] d;
    } ent_t;
    ent_t exp_q[$];
    int   push_tick_q[$];
    int   ev_tick_q[$];
    int   n_push = 0, n_addr = 0, n_data = 0, total_ev = 0;
    int   last_addr_tick = 0, last_data_tick = 0, busy_fall_tick = 0;
    int   last_addr_dout = 0, last_data_dout = 0;
    int   len_addr = 0, len_data = 0, low_cnt = 0;
    bit   have_data = 0, last_was_data = 0;
    logic prev_cs = 1'b1, prev_busy = 1'b0;
    int   m_exp_t, m_lvl;
    bit   m_busy_exp, m_expect_data;

    task automatic record_push(input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back({r, d});
        push_tick_q.push_back(tick);
        n_push++;
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        if (rst) begin
            chk("rst_cs_n", cs_n, 1);
            chk("rst_wr_n", wr_n, 1);
            chk("rst_addr", addr, 0);
            chk("rst_dout", dout, 0);
            chk("rst_level", level, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", req_ready, 0);
            exp_q.delete();
            push_tick_q.delete();
            n_push = 0; n_addr = 0; n_data = 0;
            have_data = 0; prev_cs = 1'b1; prev_busy = 1'b0; low_cnt = 0;
        end else begin
            chk("wr_n_eq_cs_n", wr_n, cs_n);
            if (prev_cs && !cs_n) begin
                total_ev++;
                ev_tick_q.push_back(tick);
                low_cnt = 0;
                m_expect_data = (n_addr > n_data);
                chk("strobe_phase", addr, m_expect_data);
                if (!addr) begin
                    if (n_addr >= n_push) begin
                        chk("strobe_allowed", cs_n, 1);
                    end else begin
                        chk("addr_dout", dout, exp_q[n_addr].r);
                        m_exp_t = push_tick_q[n_addr] + 1;
                        if (have_data && (last_data_tick + DWT + 1 > m_exp_t))
                            m_exp_t = last_data_tick + DWT + 1;
                        chk("addr_tick", tick, m_exp_t);
                    end
                    n_addr++;
                    last_addr_tick = tick;
                    last_addr_dout = dout;
                    last_was_data = 0;
                end else begin
                    if (n_data < n_push) chk("data_dout", dout, exp_q[n_data].d);
                    chk("data_tick", tick, last_addr_tick + AWT + 1);
                    n_data++;
                    last_data_tick = tick;
                    last_data_dout = dout;
                    have_data = 1;
                    last_was_data = 1;
                end
            end
            if (!cs_n) low_cnt++;
            else if (!prev_cs) begin
                if (last_was_data) len_data = low_cnt;
                else len_addr = low_cnt;
            end
            prev_cs = cs_n;
            m_lvl = n_push - n_addr;
            chk("level", level, m_lvl);
            chk("ready", req_ready, m_lvl != DEPTH);
            m_busy_exp = (m_lvl != 0) || (n_addr != n_data) ||
                         (have_data && tick < last_data_tick + DWT + 1);
            chk("busy", busy, m_busy_exp);
            if (prev_busy && !busy) busy_fall_tick = tick;
            prev_busy = busy;
        end
    end

    // Caller is at or just after a negedge; returns at the negedge after the push edge.
    task automatic push(input logic [7:0] r, input logic [7:0] d);
        int w = 0;
        while (!req_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready", req_ready, 1);
        if (!req_ready) return;
        req_reg = r;
        req_data = d;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        record_push(r, d);
    endtask

    task automatic wait_idle(input int budget);
        int w = 0;
        @(negedge clk);
        #2;
        while (busy && w < budget) begin
            @(negedge clk);
            #2;
            w++;
        end
        chk("idle_in_time", busy, 0);
    endtask

    task automatic wait_ev(input int target, input int budget);
        int w = 0;
        @(negedge clk);
        #2;
        while (total_ev < target && w < budget) begin
            @(negedge clk);
            #2;
            w++;
        end
        chk("event_in_time", total_ev >= target, 1);
    endtask

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        int period;
        int a2d;
        int idle;
        int len;
    } vec_t;
    vec_t tbl[4];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b, bd, w;
        tbl[0] = '{8'h10, 8'h55, 1, AWT + 1, DWT + 1, 1};
        tbl[1] = '{8'h10, 8'h55, 4, AWT + 1, DWT + 1, 4};
        tbl[2] = '{8'hA3, 8'h0F, 2, AWT + 1, DWT + 1, 2};
        tbl[3] = '{8'hFF, 8'h00, 3, AWT + 1, DWT + 1, 3};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single writes under several cen rates
        for (int i = 0; i < 4; i++) begin
            cen_mode = tbl[i].period;
            repeat (6) @(negedge clk);
            push(tbl[i].r, tbl[i].d);
            wait_idle(3000);
            chk("vec_addr_dout", last_addr_dout, tbl[i].r);
            chk("vec_data_dout", last_data_dout, tbl[i].d);
            chk("vec_a2d_ticks", last_data_tick - last_addr_tick, tbl[i].a2d);
            chk("vec_idle_ticks", busy_fall_tick - last_data_tick, tbl[i].idle);
            chk("vec_len_addr", len_addr, tbl[i].len);
            chk("vec_len_data", len_data, tbl[i].len);
        end

        // back-to-back: three pushes in consecutive clocks while cen is held low
        cen_mode = 0;
        repeat (3) @(negedge clk);
        b = total_ev;
        push(8'h01, 8'h11);
        chk("b2b_level1", level, 1);
        push(8'h02, 8'h22);
        chk("b2b_level2", level, 2);
        push(8'h03, 8'h33);
        chk("b2b_level3", level, 3);
        cen_mode = 1;
        wait_ev(b + 1, 200);
        chk("b2b_level_after_pop", level, 2);
        wait_ev(b + 6, 1000);
        chk("b2b_gap_ticks", ev_tick_q[b + 2] - ev_tick_q[b + 1], DWT + 1);
        chk("b2b_gap2_ticks", ev_tick_q[b + 4] - ev_tick_q[b + 3], DWT + 1);
        wait_idle(1000);

        // fill to DEPTH with cen stuck low, hold a 17th request, then release cen
        cen_mode = 0;
        repeat (3) @(negedge clk);
        bd = n_data;
        for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i), 8'h50 + 8'(i));
        chk("fill_level_full", level, DEPTH);
        chk("fill_ready_low", req_ready, 0);
        req_reg = 8'h70;
        req_data = 8'h71;
        req_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("fill_held_level", level, DEPTH);
        chk("fill_held_ready", req_ready, 0);
        chk("fill_frozen_cs_n", cs_n, 1);
        cen_mode = 1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("fill_ready_back", req_ready, 1);
        chk("fill_level_after_pop", level, DEPTH - 1);
        @(negedge clk);
        req_valid = 1'b0;
        record_push(8'h70, 8'h71);
        chk("fill_level_refilled", level, DEPTH);
        wait_idle(20 * 100);
        chk("fill_drained", n_data - bd, DEPTH + 1);

        // pointer wrap: 40 entries with distinct data, order checked by the model
        bd = n_data;
        for (int i = 0; i < 40; i++) push(8'h80 + 8'(i), 8'(i));
        wait_idle(45 * 100);
        chk("wrap_drained", n_data - bd, 40);
        chk("wrap_last_data", last_data_dout, 8'h27);

        // randomized gaps and random cen
        cen_mode = 255;
        bd = n_data;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 150)) @(negedge clk);
            push(8'($urandom()), 8'($urandom()));
        end
        wait_idle(30000);
        chk("rand_drained", n_data - bd, 30);

        // reset during the address wait of the first of five entries
        cen_mode = 1;
        repeat (3) @(negedge clk);
        b = total_ev;
        for (int i = 0; i < 5; i++) push(8'h20 + 8'(i), 8'hC0 + 8'(i));
        wait_ev(b + 1, 200);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_cs_n", cs_n, 1);
        chk("rst_async_wr_n", wr_n, 1);
        chk("rst_async_addr", addr, 0);
        chk("rst_async_dout", dout, 0);
        chk("rst_async_level", level, 0);
        chk("rst_async_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b = total_ev;
        repeat (300) @(negedge clk);
        chk("rst_no_strobes", total_ev, b);
        chk("rst_stays_idle", busy, 0);
        push(8'h33, 8'h44);
        wait_idle(500);
        chk("rst_new_write", total_ev, b + 2);
        chk("rst_new_data", last_data_dout, 8'h44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
